// File: rtl/mac_sequencer.sv
// Streaming multiply-accumulate controller around a hierarchical 32x32 Vedic multiplier.
// Optional MAC_SATURATE_EN: accumulator clamps to all-ones on carry-out instead of wrapping.

module vedic_2x2 (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [3:0] p
);
    logic t1, t2, t3, c1;

    assign t1   = a[1] & b[0];
    assign t2   = a[0] & b[1];
    assign t3   = a[1] & b[1];
    assign c1   = t1 & t2;
    assign p[0] = a[0] & b[0];
    assign p[1] = t1 ^ t2;
    assign p[2] = t3 ^ c1;
    assign p[3] = t3 & c1;
endmodule

// Each level: four half-width partial products, cross terms summed then shifted into place.
module vedic_4x4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);
    logic [3:0] q0, q1, q2, q3;
    logic [4:0] mid;

    vedic_2x2 u_ll (.a(a[1:0]), .b(b[1:0]), .p(q0));
    vedic_2x2 u_hl (.a(a[3:2]), .b(b[1:0]), .p(q1));
    vedic_2x2 u_lh (.a(a[1:0]), .b(b[3:2]), .p(q2));
    vedic_2x2 u_hh (.a(a[3:2]), .b(b[3:2]), .p(q3));

    assign mid = {1'b0, q1} + {1'b0, q2};
    assign p   = {q3, q0} + {1'b0, mid, 2'b0};
endmodule

module vedic_8x8 (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] p
);
    logic [7:0] q0, q1, q2, q3;
    logic [8:0] mid;

    vedic_4x4 u_ll (.a(a[3:0]), .b(b[3:0]), .p(q0));
    vedic_4x4 u_hl (.a(a[7:4]), .b(b[3:0]), .p(q1));
    vedic_4x4 u_lh (.a(a[3:0]), .b(b[7:4]), .p(q2));
    vedic_4x4 u_hh (.a(a[7:4]), .b(b[7:4]), .p(q3));

    assign mid = {1'b0, q1} + {1'b0, q2};
    assign p   = {q3, q0} + {3'b0, mid, 4'b0};
endmodule

module vedic_16x16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [31:0] p
);
    logic [15:0] q0, q1, q2, q3;
    logic [16:0] mid;

    vedic_8x8 u_ll (.a(a[7:0]),  .b(b[7:0]),  .p(q0));
    vedic_8x8 u_hl (.a(a[15:8]), .b(b[7:0]),  .p(q1));
    vedic_8x8 u_lh (.a(a[7:0]),  .b(b[15:8]), .p(q2));
    vedic_8x8 u_hh (.a(a[15:8]), .b(b[15:8]), .p(q3));

    assign mid = {1'b0, q1} + {1'b0, q2};
    assign p   = {q3, q0} + {7'b0, mid, 8'b0};
endmodule

module vedic_32x32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] p
);
    logic [31:0] q0, q1, q2, q3;
    logic [32:0] mid;

    vedic_16x16 u_ll (.a(a[15:0]),  .b(b[15:0]),  .p(q0));
    vedic_16x16 u_hl (.a(a[31:16]), .b(b[15:0]),  .p(q1));
    vedic_16x16 u_lh (.a(a[15:0]),  .b(b[31:16]), .p(q2));
    vedic_16x16 u_hh (.a(a[31:16]), .b(b[31:16]), .p(q3));

    assign mid = {1'b0, q1} + {1'b0, q2};
    assign p   = {q3, q0} + {15'b0, mid, 16'b0};
endmodule

// Handshakes: a transfer occurs on a rising edge where valid and ready are both high;
// out_valid is held with out_acc/out_ovf stable until out_ready is seen.
module mac_sequencer #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_acc,
    output logic             out_ovf,
    output logic             busy
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [LEN_W-1:0] remaining, remaining_nxt;
    logic [31:0]      a_r, a_nxt;
    logic [31:0]      b_r, b_nxt;
    logic             s1_valid, s1_valid_nxt;
    logic [63:0]      acc, acc_nxt;
    logic             ovf, ovf_nxt;

    logic [63:0]      prod;
    logic [64:0]      sum;
    logic [63:0]      acc_add;
    logic             accept;

    vedic_32x32 u_mul (.a(a_r), .b(b_r), .p(prod));

    assign sum = {1'b0, acc} + {1'b0, prod};

`ifdef MAC_SATURATE_EN
    // Once clamped, any further non-zero product carries out again, so the clamp persists.
    assign acc_add = sum[64] ? 64'hFFFF_FFFF_FFFF_FFFF : sum[63:0];
`else
    assign acc_add = sum[63:0];
`endif

    assign in_ready  = (state == RUN) && (remaining != '0);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);
    assign out_acc   = acc;
    assign out_ovf   = ovf;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            remaining <= '0;
            a_r       <= '0;
            b_r       <= '0;
            s1_valid  <= 1'b0;
            acc       <= '0;
            ovf       <= 1'b0;
        end else begin
            state     <= state_nxt;
            remaining <= remaining_nxt;
            a_r       <= a_nxt;
            b_r       <= b_nxt;
            s1_valid  <= s1_valid_nxt;
            acc       <= acc_nxt;
            ovf       <= ovf_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        a_nxt         = a_r;
        b_nxt         = b_r;
        s1_valid_nxt  = s1_valid;
        acc_nxt       = acc;
        ovf_nxt       = ovf;

        case (state)
            IDLE: begin
                if (start) begin
                    acc_nxt      = '0;
                    ovf_nxt      = 1'b0;
                    s1_valid_nxt = 1'b0;
                    if (len != '0) begin
                        remaining_nxt = len;
                        state_nxt     = RUN;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    a_nxt         = in_a;
                    b_nxt         = in_b;
                    remaining_nxt = remaining - LEN_W'(1);
                end
                s1_valid_nxt = accept;
                if (s1_valid) begin
                    acc_nxt = acc_add;
                    ovf_nxt = ovf | sum[64];
                    // Last term is in the multiplier stage: nothing left to accept.
                    if (remaining == '0) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_mac_sequencer.sv
// Self-checking bench for mac_sequencer: run-level sum model, per-cycle compare, directed and random runs.
module tb_mac_sequencer;
  localparam int LEN_W = 8;

`ifdef MAC_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len_i = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_a = '0;
  logic [31:0]      in_b = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [63:0]      out_acc;
  logic             out_ovf;
  logic             busy;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  mac_sequencer #(.LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len_i),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
    .out_ovf(out_ovf), .busy(busy)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Run-level view: a run is len accepted pairs; the result is their exact sum, truncated
  // (or clamped) to 64 bits, with overflow meaning the exact sum exceeds 64 bits.
  int             m_mode = 0;   // 0 idle, 1 collecting, 2 result presented
  int             m_left = 0;
  logic [127:0]   m_true = '0;
  bit             m_fresh = 1'b1;
  logic [64:0]    exp_q[$];

  task automatic push_result();
    logic        ovf;
    logic [63:0] acc;
    ovf = |m_true[127:64];
    acc = (SAT && ovf) ? 64'hFFFF_FFFF_FFFF_FFFF : m_true[63:0];
    exp_q.push_back({ovf, acc});
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      m_mode  = 0;
      m_left  = 0;
      m_true  = '0;
      m_fresh = 1'b1;
      exp_q.delete();
    end else begin
      case (m_mode)
        0: if (start) begin
          m_true  = '0;
          m_fresh = 1'b0;
          if (len_i != 0) begin
            m_mode = 1;
            m_left = int'(len_i);
          end else begin
            m_mode = 2;
            push_result();
          end
        end
        1: begin
          if (m_left == 0) begin
            m_mode = 2;
            push_result();
          end else if (in_valid) begin
            m_true = m_true + 128'(64'(in_a) * 64'(in_b));
            m_left = m_left - 1;
          end
        end
        default: if (out_ready) m_mode = 0;
      endcase
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", 64'(in_ready), 64'(m_mode == 1 && m_left != 0));
      check("out_valid", 64'(out_valid), 64'(m_mode == 2));
      check("busy", 64'(busy), 64'(m_mode != 0));
      if (m_fresh) begin
        check("idle_acc", out_acc, 64'd0);
        check("idle_ovf", 64'(out_ovf), 64'd0);
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got acc %h with no expected result", out_acc);
        end else begin
          check("sb_acc", out_acc, exp_q[0][63:0]);
          check("sb_ovf", 64'(out_ovf), 64'(exp_q[0][64]));
          if (out_ready && rst_n) void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_run(input int l);
    start = 1'b1;
    len_i = LEN_W'(l);
    step();
    start = 1'b0;
    len_i = LEN_W'($urandom);
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input int bubbles);
    in_valid = 1'b0;
    repeat (bubbles) step();
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    for (int t = 0; t < 100 && !in_ready; t++) step();
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready got 0 required 1");
    end
    step();
    in_valid = 1'b0;
    in_a = $urandom;
    in_b = $urandom;
  endtask

  task automatic finish_run(input int stall, input bit pulse_start,
                            output logic [63:0] acc, output logic ovf, output int lat);
    lat = 0;
    out_ready = 1'b0;
    while (!out_valid && lat < 100) begin
      step();
      lat++;
    end
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: out_valid got 0 required 1");
    end
    acc = out_acc;
    ovf = out_ovf;
    repeat (stall) begin
      if (pulse_start) begin
        start = 1'b1;
        len_i = LEN_W'(5);
      end
      step();
    end
    start = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  function automatic logic [31:0] rand_operand();
    if ($urandom_range(0, 3) == 0) return $urandom | 32'hF000_0000;
    return $urandom;
  endfunction

  // ---------------- stimulus ----------------
  logic [63:0] r_acc;
  logic        r_ovf;
  int          r_lat;

  initial begin
    rst_n = 1'b0;
    step();
    chk_en = 1'b1;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_acc", out_acc, 64'd0);
    check("rst_out_ovf", 64'(out_ovf), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    step();
    rst_n = 1'b1;
    step();

    // back-to-back three terms
    begin_run(3);
    send(32'd12, 32'd12, 0);
    send(32'd15, 32'd13, 0);
    send(32'd24, 32'd2, 0);
    finish_run(0, 1'b0, r_acc, r_ovf, r_lat);
    check("t1_acc", r_acc, 64'd387);
    check("t1_ovf", 64'(r_ovf), 64'd0);
    check("t1_latency", 64'(r_lat), 64'd1);

    // bubbles between pairs, consumer stalls in DONE
    begin_run(3);
    send(32'd12, 32'd12, 0);
    send(32'd15, 32'd13, 2);
    send(32'd24, 32'd2, 2);
    finish_run(5, 1'b0, r_acc, r_ovf, r_lat);
    check("t2_acc", r_acc, 64'd387);
    check("t2_ovf", 64'(r_ovf), 64'd0);

    // zero-length run
    begin_run(0);
    finish_run(1, 1'b0, r_acc, r_ovf, r_lat);
    check("t3_acc", r_acc, 64'd0);
    check("t3_latency", 64'(r_lat), 64'd0);

    // carry out of bit 63
    begin_run(2);
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    finish_run(0, 1'b0, r_acc, r_ovf, r_lat);
    check("t4_acc", r_acc, SAT ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFC_0000_0002);
    check("t4_ovf", 64'(r_ovf), 64'd1);

    // start pulses in RUN and DONE must be ignored
    begin_run(2);
    send(32'd3, 32'd4, 0);
    start = 1'b1;
    len_i = LEN_W'(5);
    step();
    start = 1'b0;
    send(32'd5, 32'd6, 1);
    finish_run(3, 1'b1, r_acc, r_ovf, r_lat);
    check("t5_acc", r_acc, 64'd42);
    step();
    check("t5_idle_busy", 64'(busy), 64'd0);

    // reset mid-run discards the partial result
    begin_run(4);
    send(32'd7, 32'd9, 0);
    send(32'd11, 32'd13, 0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("t6_rst_in_ready", 64'(in_ready), 64'd0);
    check("t6_rst_out_valid", 64'(out_valid), 64'd0);
    check("t6_rst_out_acc", out_acc, 64'd0);
    check("t6_rst_busy", 64'(busy), 64'd0);
    begin_run(1);
    send(32'd200, 32'd21, 0);
    finish_run(0, 1'b0, r_acc, r_ovf, r_lat);
    check("t6_acc", r_acc, 64'd4200);

    // randomized runs against the model
    for (int r = 0; r < 40; r++) begin
      int l;
      l = $urandom_range(0, 12);
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) step();
      begin_run(l);
      for (int i = 0; i < l; i++) begin
        send(rand_operand(), rand_operand(),
             ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0);
      end
      finish_run($urandom_range(0, 3), 1'(($urandom_range(0, 1))), r_acc, r_ovf, r_lat);
    end

    repeat (3) step();
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL leftover_results: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    checks++;
    $display("FAIL global_timeout: simulation did not complete");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mac_sequencer.md
# mac_sequencer

Sequencing controller that turns the combinational 32x32 Vedic multiplier into a streaming multiply-accumulate unit. It accepts a programmed number of operand pairs over a valid/ready input stream, registers each pair in front of one internal `vedic_32x32` instance, and adds each 64-bit product into a 64-bit accumulator. When the last term is accumulated it presents the sum on a held valid/ready output. It is the top-level MAC block fed by the operand source and drained by the result consumer.

## Interface
- `LEN_W`, default 8: width of the term-count field. Maximum run length is 2^LEN_W-1 terms.

Ports:
- `clk` input 1: single clock. All state updates on the rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `start` input 1: starts a run. Sampled only in IDLE.
- `len` input LEN_W: number of terms in the run. Sampled when `start` is accepted.
- `in_valid` input 1: operand pair valid.
- `in_ready` output 1: block accepts an operand pair this cycle.
- `in_a` input 32: multiplicand, unsigned.
- `in_b` input 32: multiplier, unsigned.
- `out_valid` output 1: accumulated result valid.
- `out_ready` input 1: consumer takes the result.
- `out_acc` output 64: accumulated sum.
- `out_ovf` output 1: sticky flag, set if any accumulate step carried out of bit 63 during this run.
- `busy` output 1: high in any state other than IDLE.

## Operation
States:
- IDLE
  - `start`=1 and `len`≠0: latch `len` into `remaining`, clear the accumulator and `ovf`, go to RUN.
  - `start`=1 and `len`=0: clear the accumulator and `ovf`, go to DONE. The result is 0.
- RUN
  - `in_ready` = (`remaining`≠0).
  - Accept: `in_valid`&`in_ready` at an edge.
    - Load `a_r`/`b_r` with the operands and set `s1_valid`.
    - Decrement `remaining`.
  - Any edge with `s1_valid`=1:
    - `acc` ← `acc` + `vedic_32x32(a_r,b_r)`.
    - `ovf` |= carry-out.
    - Clear `s1_valid` unless a new pair is accepted on the same edge.
  - Exit: at the edge where the final term is accumulated (`remaining`=0, `s1_valid`=1), go to DONE.
- DONE
  - `out_valid`=1.
  - `out_acc` and `out_ovf` are held stable.
  - `out_valid`&`out_ready` at an edge: go to IDLE.

Rules:
- `start` in RUN or DONE is ignored.
- `len` is ignored outside the start-accept edge.
- Input bubbles (`in_valid`=0) stall the run indefinitely with no state loss.
- Arithmetic:
  - The product is the full unsigned 64-bit value.
  - The accumulator add is 65-bit internally. Bit 64 is the carry-out.
  - Default behaviour stores the sum modulo 2^64.

## Timing
- Reset values:
  - State: IDLE.
  - `in_ready`=0, `out_valid`=0, `out_acc`=0, `out_ovf`=0, `busy`=0.
  - Internal: `s1_valid`=0, `remaining`=0.
- Reset asserted mid-run or in DONE aborts at the next edge and discards the partial result. No output pulse is produced.
- Throughput: one term per cycle while `in_valid` is held high.
- Latency:
  - A pair accepted at edge E is added to `acc` at edge E+1.
  - With zero-length runs and all-1 `in_valid` excluded: `out_valid` is first high in the cycle after the last accept edge plus one edge (last accept at E, DONE entered at E+1).
  - `len`=0: `out_valid` is high in the cycle after the start edge.
- `in_ready` is combinational from state and `remaining`. It drops in the cycle after the last accept.
- Simultaneous accept and accumulate on one edge is normal pipelined operation. Both the accumulate and the register load happen on that edge.
- A new `start` can be accepted no earlier than the cycle after the `out_valid`&`out_ready` edge.

## Configuration
- `MAC_SATURATE_EN`
  - Defined: on an add with carry-out, `acc` is forced to 64'hFFFF_FFFF_FFFF_FFFF and stays there for the rest of the run. `ovf` is still set.
  - Undefined: the accumulator wraps modulo 2^64 and `ovf` is set.

## Test plan
- `len`=3, pairs (12,12), (15,13), (24,2) back-to-back → `out_acc`=387, `out_ovf`=0, `out_valid` one cycle after the accumulate of the third term.
- Same run with `in_valid` low for 2 cycles between pairs and `out_ready` low for 5 cycles in DONE → `out_acc`=387 held stable, `in_ready` drops after the 3rd accept, IDLE only after the `out_ready` edge.
- `len`=0 with `start` → DONE next cycle, `out_acc`=0, no `in_ready` assertion.
- `len`=2, pairs (0xFFFFFFFF,0xFFFFFFFF) twice:
  - Without the macro → `out_acc`=0xFFFFFFFC00000002, `out_ovf`=1.
  - With `MAC_SATURATE_EN` → 0xFFFFFFFFFFFFFFFF, `out_ovf`=1.
- `start` pulsed with `len`=5 during RUN and during DONE → ignored. The run completes with the original `len`; `remaining` is not altered.
- `rst_n`=0 for one cycle after 2 of 4 terms → all outputs at reset values next cycle. A following run with `len`=1 and pair (200,21) → `out_acc`=4200.
